// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM state type and decode helpers.
// MISALIGN_TRAP_EN (optional) enables the misalignment check helper's use in the top level.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_RD  = 3'd1,
        STORE_RD = 3'd2,
        STORE_WR = 3'd3,
        DONE     = 3'd4
    } lsu_state_t;

    // Stores only accept B/H/W; loads additionally accept BU/HU.
    function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
        if (is_store) begin
            return f3[2] || (f3 == 3'b011);
        end
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/half lane handling: extracts and extends load data, merges SB/SH data into a read word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] store_data,
    output logic [31:0] load_data_c,
    output logic [31:0] merge_data_c
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v       = rdata[{addr_lo, 3'b000} +: 8];
        half_v       = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        load_data_c  = rdata;
        unique case (funct3)
            F3_B:    load_data_c = {{24{byte_v[7]}}, byte_v};
            F3_BU:   load_data_c = {24'h000000, byte_v};
            F3_H:    load_data_c = {{16{half_v[15]}}, half_v};
            F3_HU:   load_data_c = {16'h0000, half_v};
            default: load_data_c = rdata;
        endcase

        // Bytes outside the addressed lane keep the value read from memory.
        merge_data_c = rdata;
        unique case (funct3)
            F3_B:    merge_data_c[{addr_lo, 3'b000} +: 8] = store_data[7:0];
            F3_H: begin
                if (addr_lo[1]) begin
                    merge_data_c[31:16] = store_data[15:0];
                end else begin
                    merge_data_c[15:0] = store_data[15:0];
                end
            end
            default: merge_data_c = store_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single-request FSM driving a word-wide data memory, with read-modify-write for SB/SH.
// Define MISALIGN_TRAP_EN to fault misaligned halfword/word accesses instead of ignoring the low bits.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_load,
    input  logic                  req_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_store_data,
    output logic                  resp_valid,
    output logic [31:0]           resp_data,
    output logic                  resp_fault,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_write_data,
    input  logic [31:0]           mem_read_data
);

    lsu_state_t            state_q, state_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            addr_lo_q, addr_lo_d;
    logic [31:0]           store_data_q, store_data_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [31:0]           mem_write_data_q, mem_write_data_d;
    logic [31:0]           resp_data_q, resp_data_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_fault_q, resp_fault_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic                  req_ready_q, req_ready_d;

    logic                  acc_store_c;
    logic                  acc_load_c;
    logic                  acc_fault_c;
    logic [31:0]           load_data_c;
    logic [31:0]           merge_data_c;

    lsu_lane_align u_lane_align (
        .funct3       (funct3_q),
        .addr_lo      (addr_lo_q),
        .rdata        (mem_read_data),
        .store_data   (store_data_q),
        .load_data_c  (load_data_c),
        .merge_data_c (merge_data_c)
    );

    // Request decode; store takes priority when both op bits are set.
    always_comb begin
        acc_store_c = req_store;
        acc_load_c  = req_load && !req_store;
        acc_fault_c = 1'b0;
        if (acc_store_c || acc_load_c) begin
            acc_fault_c = f3_illegal(acc_store_c, req_funct3);
`ifdef MISALIGN_TRAP_EN
            if (f3_misaligned(req_funct3, req_addr[1:0])) begin
                acc_fault_c = 1'b1;
            end
`endif
        end
    end

    // Next-state and registered strobe/response values.
    always_comb begin
        state_d          = state_q;
        funct3_d         = funct3_q;
        addr_lo_d        = addr_lo_q;
        store_data_d     = store_data_q;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;
        resp_data_d      = 32'h0;
        resp_valid_d     = 1'b0;
        resp_fault_d     = 1'b0;
        mem_read_d       = 1'b0;
        mem_write_d      = 1'b0;
        req_ready_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    funct3_d     = req_funct3;
                    addr_lo_d    = req_addr[1:0];
                    store_data_d = req_store_data;
                    if (acc_fault_c || !(acc_store_c || acc_load_c)) begin
                        state_d      = DONE;
                        resp_valid_d = 1'b1;
                        resp_fault_d = acc_fault_c;
                    end else begin
                        mem_address_d = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        if (acc_load_c) begin
                            state_d    = LOAD_RD;
                            mem_read_d = 1'b1;
                        end else if (req_funct3 == F3_W) begin
                            state_d          = STORE_WR;
                            mem_write_d      = 1'b1;
                            mem_write_data_d = req_store_data;
                        end else begin
                            state_d    = STORE_RD;
                            mem_read_d = 1'b1;
                        end
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            LOAD_RD: begin
                state_d      = DONE;
                resp_valid_d = 1'b1;
                resp_data_d  = load_data_c;
            end
            STORE_RD: begin
                state_d          = STORE_WR;
                mem_write_d      = 1'b1;
                mem_write_data_d = merge_data_c;
            end
            STORE_WR: begin
                state_d      = DONE;
                resp_valid_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            funct3_q         <= 3'b000;
            addr_lo_q        <= 2'b00;
            store_data_q     <= 32'h0;
            mem_address_q    <= '0;
            mem_write_data_q <= 32'h0;
            resp_data_q      <= 32'h0;
            resp_valid_q     <= 1'b0;
            resp_fault_q     <= 1'b0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            req_ready_q      <= 1'b1;
        end else begin
            state_q          <= state_d;
            funct3_q         <= funct3_d;
            addr_lo_q        <= addr_lo_d;
            store_data_q     <= store_data_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
            resp_data_q      <= resp_data_d;
            resp_valid_q     <= resp_valid_d;
            resp_fault_q     <= resp_fault_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
            req_ready_q      <= req_ready_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_data      = resp_data_q;
    assign resp_fault     = resp_fault_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: 64-word memory, byte-level reference model, directed + random requests.
module tb_load_store_unit;

    typedef struct packed {
        logic [3:0]  lat;
        logic [31:0] data;
        logic        fault;
        logic [3:0]  reads;
        logic [3:0]  writes;
        logic [3:0]  both;
        logic [3:0]  aerr;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_load, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_store_data;
    logic        resp_valid, resp_fault, mem_read, mem_write;
    logic [31:0] resp_data, mem_address, mem_write_data, mem_read_data;

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic        pre_we;
    logic [5:0]  pre_idx;
    logic [31:0] pre_data;
    int          wr_cnt;
    int          n_cmp, n_fail;
    int          last_tries;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_load       (req_load),
        .req_store      (req_store),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_store_data (req_store_data),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .resp_fault     (resp_fault),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    assign mem_read_data = mem[mem_address[7:2]];

    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_address[7:2]] <= mem_write_data;
            wr_cnt <= wr_cnt + 1;
        end else if (pre_we) begin
            mem[pre_idx] <= pre_data;
        end
    end

    // Reference behaviour computed from byte lanes and masks.
    function automatic txn_t model(input bit ld, input bit st, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] data,
                                   input logic [31:0] old, output logic [31:0] nw);
        txn_t        e;
        bit          is_st, is_ld, bad;
        int          sh, hsh;
        logic [7:0]  b8;
        logic [15:0] h16;
        logic [31:0] mask;
        e     = '0;
        nw    = old;
        is_st = st;
        is_ld = ld && !st;
        sh    = 8 * int'(addr[1:0]);
        hsh   = 16 * int'(addr[1]);
        if (!is_st && !is_ld) begin
            e.lat = 4'd1;
            return e;
        end
        bad = is_st ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef MISALIGN_TRAP_EN
        if ((f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00)) bad = 1'b1;
`endif
        if (bad) begin
            e.lat   = 4'd1;
            e.fault = 1'b1;
            return e;
        end
        b8  = 8'(old >> sh);
        h16 = 16'(old >> hsh);
        if (is_ld) begin
            e.lat   = 4'd2;
            e.reads = 4'd1;
            case (f3)
                3'd0:    e.data = {{24{b8[7]}}, b8};
                3'd4:    e.data = {24'h0, b8};
                3'd1:    e.data = {{16{h16[15]}}, h16};
                3'd5:    e.data = {16'h0, h16};
                default: e.data = old;
            endcase
        end else if (f3 == 3'd2) begin
            e.lat    = 4'd2;
            e.writes = 4'd1;
            nw       = data;
        end else begin
            e.lat    = 4'd3;
            e.reads  = 4'd1;
            e.writes = 4'd1;
            mask     = (f3 == 3'd0) ? (32'hFF << sh) : (32'hFFFF << hsh);
            nw       = (old & ~mask) | ((data << ((f3 == 3'd0) ? sh : hsh)) & mask);
        end
        return e;
    endfunction

    task automatic preload(input int idx, input logic [31:0] v);
        pre_idx  = 6'(idx);
        pre_data = v;
        pre_we   = 1'b1;
        @(negedge clk);
        pre_we   = 1'b0;
        ref_mem[idx] = v;
    endtask

    // Issues one request (starting at a negedge) and records what the memory port and response did.
    task automatic do_txn(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] data, output txn_t o, output txn_t e);
        bit          rdy, acc;
        logic [31:0] ea, nw;
        int          idx;
        idx = int'(addr[7:2]);
        e   = model(ld, st, f3, addr, data, ref_mem[idx], nw);
        ref_mem[idx] = nw;
        o   = '0;
        ea  = {addr[31:2], 2'b00};
        req_load = ld; req_store = st; req_funct3 = f3; req_addr = addr; req_store_data = data;
        req_valid = 1'b1;
        acc = 1'b0;
        last_tries = 0;
        for (int i = 0; i < 4 && !acc; i++) begin
            rdy = req_ready;
            last_tries++;
            @(posedge clk);
            acc = rdy;
            if (!acc) @(negedge clk);
        end
        #1 req_valid = 1'b0;
        if (!acc) begin
            o.lat = 4'hF;
            return;
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem_read) o.reads++;
            if (mem_write) o.writes++;
            if (mem_read && mem_write) o.both++;
            if ((mem_read || mem_write) && mem_address !== ea) o.aerr++;
            if (resp_valid) begin
                o.lat   = 4'(k);
                o.data  = resp_data;
                o.fault = resp_fault;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({req_ready, resp_valid, resp_fault, mem_read, mem_write} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 10000", {req_ready, resp_valid, resp_fault, mem_read, mem_write});
        end
        n_cmp++;
        if ({resp_data, mem_address, mem_write_data} !== 96'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h want zeros", resp_data, mem_address, mem_write_data);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_loads();
        logic [2:0]  f3s   [4] = '{3'd2, 3'd0, 3'd4, 3'd5};
        logic [31:0] addrs [4] = '{32'h10, 32'h13, 32'h13, 32'h12};
        logic [31:0] words [4] = '{32'hCAFEBABE, 32'h80FF0000, 32'h80FF0000, 32'h80FF0000};
        logic [31:0] wants [4] = '{32'hCAFEBABE, 32'hFFFFFF80, 32'h00000080, 32'h000080FF};
        txn_t o, e;
        for (int i = 0; i < 4; i++) begin
            preload(4, words[i]);
            do_txn(1'b1, 1'b0, f3s[i], addrs[i], 32'h0, o, e);
            n_cmp++;
            if (o !== e || o.data !== wants[i]) begin
                n_fail++;
                $display("FAIL load_%0d: got lat=%0d data=%h fault=%b rd=%0d wr=%0d aerr=%0d want lat=%0d data=%h fault=%b rd=%0d wr=%0d",
                         i, o.lat, o.data, o.fault, o.reads, o.writes, o.aerr, e.lat, wants[i], e.fault, e.reads, e.writes);
            end
        end
    endtask

    task automatic test_stores();
        txn_t o, e;
        int   w0;
        preload(8, 32'h11223344);
        do_txn(1'b0, 1'b1, 3'd0, 32'h21, 32'h000000AB, o, e);
        n_cmp++;
        if (o !== e || o.lat !== 4'd3 || o.both !== 4'd0) begin
            n_fail++;
            $display("FAIL sb: got lat=%0d rd=%0d wr=%0d both=%0d aerr=%0d want lat=3 rd=1 wr=1 both=0", o.lat, o.reads, o.writes, o.both, o.aerr);
        end
        n_cmp++;
        if (mem[8] !== 32'h1122AB44) begin
            n_fail++;
            $display("FAIL sb_word: got %h want 1122ab44", mem[8]);
        end
        w0 = wr_cnt;
        do_txn(1'b0, 1'b1, 3'd2, 32'h08, 32'hDEAD0001, o, e);
        n_cmp++;
        if (o !== e || o.lat !== 4'd2 || o.reads !== 4'd0 || mem[2] !== 32'hDEAD0001 || wr_cnt - w0 !== 1) begin
            n_fail++;
            $display("FAIL sw: got lat=%0d rd=%0d wr=%0d word=%h wrcnt=%0d want lat=2 rd=0 wr=1 word=dead0001 wrcnt=1",
                     o.lat, o.reads, o.writes, mem[2], wr_cnt - w0);
        end
    endtask

    task automatic test_faults();
        logic [2:0] f3s [4] = '{3'd7, 3'd3, 3'd4, 3'd1};
        bit         sts [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] ads [4] = '{32'h0, 32'h4, 32'h8, 32'h5};
        txn_t o, e;
        for (int i = 0; i < 4; i++) begin
            do_txn(!sts[i], sts[i], f3s[i], ads[i], 32'h12345678, o, e);
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL fault_%0d: got lat=%0d data=%h fault=%b rd=%0d wr=%0d aerr=%0d want lat=%0d data=%h fault=%b rd=%0d wr=%0d",
                         i, o.lat, o.data, o.fault, o.reads, o.writes, o.aerr, e.lat, e.data, e.fault, e.reads, e.writes);
            end
        end
        do_txn(1'b0, 1'b0, 3'd2, 32'h10, 32'h0, o, e);
        n_cmp++;
        if (o !== e || o.lat !== 4'd1 || o.fault !== 1'b0) begin
            n_fail++;
            $display("FAIL no_op: got lat=%0d fault=%b rd=%0d wr=%0d want lat=1 fault=0 rd=0 wr=0", o.lat, o.fault, o.reads, o.writes);
        end
    endtask

    task automatic test_reset_mid();
        int w0;
        preload(9, 32'hA5A5A5A5);
        w0 = wr_cnt;
        req_load = 1'b0; req_store = 1'b1; req_funct3 = 3'd1; req_addr = 32'h26; req_store_data = 32'h0000BEEF;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (mem_read !== 1'b1) begin
            n_fail++;
            $display("FAIL rmw_read: got %b want 1", mem_read);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if ({req_ready, mem_read, mem_write, resp_valid} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_mid: got %b want 1000", {req_ready, mem_read, mem_write, resp_valid});
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (wr_cnt != w0 || mem[9] !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL reset_abandon: got writes=%0d word=%h want writes=0 word=a5a5a5a5", wr_cnt - w0, mem[9]);
        end
    endtask

    task automatic rand_req(output bit ld, output bit st, output logic [2:0] f3,
                            output logic [31:0] addr, output logic [31:0] data);
        int op;
        op   = $urandom_range(0, 9);
        ld   = (op < 5) || (op == 9);
        st   = (op >= 5) && (op != 9) || (op == 8);
        f3   = 3'($urandom_range(0, 7));
        addr = 32'($urandom_range(0, 255));
        data = $urandom;
    endtask

    task automatic test_random();
        bit ld, st;
        logic [2:0] f3;
        logic [31:0] addr, data;
        txn_t o, e;
        for (int i = 0; i < 200; i++) begin
            rand_req(ld, st, f3, addr, data);
            do_txn(ld, st, f3, addr, data, o, e);
            n_cmp++;
            if (o !== e || mem[addr[7:2]] !== ref_mem[addr[7:2]]) begin
                n_fail++;
                $display("FAIL rand_%0d ld=%b st=%b f3=%0d a=%h d=%h: got lat=%0d data=%h fault=%b rd=%0d wr=%0d both=%0d aerr=%0d word=%h want lat=%0d data=%h fault=%b rd=%0d wr=%0d word=%h",
                         i, ld, st, f3, addr, data, o.lat, o.data, o.fault, o.reads, o.writes, o.both, o.aerr,
                         mem[addr[7:2]], e.lat, e.data, e.fault, e.reads, e.writes, ref_mem[addr[7:2]]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ld, st;
        logic [2:0] f3;
        logic [31:0] addr, data;
        txn_t o, e;
        for (int i = 0; i < 20; i++) begin
            rand_req(ld, st, f3, addr, data);
            do_txn(ld, st, f3, addr, data, o, e);
            n_cmp++;
            if (o !== e || last_tries != 2) begin
                n_fail++;
                $display("FAIL b2b_%0d: got lat=%0d data=%h fault=%b tries=%0d want lat=%0d data=%h fault=%b tries=2",
                         i, o.lat, o.data, o.fault, last_tries, e.lat, e.data, e.fault);
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; wr_cnt = 0; last_tries = 0;
        reset = 1'b1; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
        req_funct3 = 3'd0; req_addr = 32'h0; req_store_data = 32'h0;
        pre_we = 1'b0; pre_idx = 6'd0; pre_data = 32'h0;
        @(negedge clk);
        for (int i = 0; i < 64; i++) preload(i, $urandom);
        test_reset();
        test_loads();
        test_stores();
        test_faults();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
